// File: rtl/lv1b_trig_arbiter_pkg.sv
// Shared types and helpers for the trigger arbitration blocks.
// The round-robin search lives here so the lv1b and lv1a merge paths share one definition.
package cdt_trig_pkg;

  localparam int N_TYPE_MAX = 16;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_DEAD = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    DEAD = ST_DEAD
  } state_t;

  // Returns {found, index} of the first set bit of req, starting at ptr and
  // wrapping at n.
  // ptr is expected to be below n.
  // Bits at or above n are never examined.
  function automatic logic [4:0] first_set_from(input logic [N_TYPE_MAX-1:0] req,
                                                input logic [3:0]            ptr,
                                                input int                    n);
    logic [4:0] res;
    int         j;
    res = '0;
    for (int i = 0; i < N_TYPE_MAX; i++) begin
      j = int'(ptr) + i;
      if (j >= n) j = j - n;
      if ((i < n) && !res[4] && req[j[3:0]]) res = {1'b1, j[3:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/lv1b_trig_arbiter_rr_arb_n.sv
// Combinational round-robin pick.
// Grants the first requesting bit at or after ptr, wrapping around.
module rr_arb_n
  import cdt_trig_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   ptr,
  output logic [3:0]   grant_idx,
  output logic         grant_vld
);

  logic [N_TYPE_MAX-1:0] req_ext;
  logic [4:0]            pick;

  // Widen the request to the package search width and run the wrap-around search
  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req;
    pick             = first_set_from(req_ext, ptr, N);
  end

  assign grant_idx = pick[3:0];
  assign grant_vld = pick[4];

endmodule

// File: rtl/lv1b_trig_arbiter.sv
// lv1b trigger arbiter.
// Merges per-type scaled requests into one accept stream.
// Applies round-robin fairness, a programmable deadtime and a DAQ busy hold-off.
// Also keeps per-run accept/veto scalers.
module lv1b_trig_arbiter
  import cdt_trig_pkg::*;
#(
  parameter int N_TYPE = 8,
  parameter int DT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_live,
  input  logic              in_ena,
  input  logic              in_daq_busy,
  input  logic [N_TYPE-1:0] in_trig_scaled,
  input  logic [DT_W-1:0]   user_deadtime,
  input  logic [N_TYPE-1:0] user_type_mask,
  output logic              out_lv1b,
  output logic [3:0]        out_trig_type,
  output logic [N_TYPE-1:0] out_trig_pattern,
  output logic              out_busy,
  output logic [31:0]       accept_cnt,
  output logic [31:0]       veto_cnt
);

  state_t            state, state_next;
  logic [DT_W-1:0]   dead_cnt, dead_cnt_next;
  logic [3:0]        rr_ptr, rr_ptr_next;
  logic              pre_live;

  logic [N_TYPE-1:0] req;
  logic              live_edge;
  logic [3:0]        arb_ptr;
  logic [3:0]        grant_idx;
  logic              grant_vld;
  logic              can_acc;
  logic              accept;

  logic              lv1b_next;
  logic [3:0]        type_next;
  logic [N_TYPE-1:0] pattern_next;
  logic              busy_next;
  logic [31:0]       accept_cnt_next;
  logic [31:0]       veto_cnt_next;

  assign req       = in_trig_scaled & user_type_mask;
  assign live_edge = in_live & ~pre_live;
  // A new run restarts fairness at type 0, including for an accept on the edge cycle itself.
  assign arb_ptr   = live_edge ? 4'd0 : rr_ptr;
  assign can_acc   = (state == IDLE) & in_live & in_ena & ~in_daq_busy;
  assign accept    = can_acc & grant_vld;

  rr_arb_n #(.N(N_TYPE)) u_arb (
    .req       (req),
    .ptr       (arb_ptr),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Next-state, deadtime, fairness pointer, scalers and registered outputs
  always_comb begin
    state_next      = state;
    dead_cnt_next   = dead_cnt;
    rr_ptr_next     = arb_ptr;
    lv1b_next       = 1'b0;
    type_next       = out_trig_type;
    pattern_next    = out_trig_pattern;
    accept_cnt_next = live_edge ? 32'd0 : accept_cnt;
    veto_cnt_next   = live_edge ? 32'd0 : veto_cnt;

    case (state)
      IDLE: begin
        if (accept) begin
          lv1b_next    = 1'b1;
          type_next    = grant_idx;
          pattern_next = req;
          rr_ptr_next  = (grant_idx == 4'(N_TYPE - 1)) ? 4'd0 : grant_idx + 4'd1;
          if (accept_cnt_next != 32'hFFFF_FFFF) accept_cnt_next = accept_cnt_next + 32'd1;
          if (user_deadtime != '0) begin
            dead_cnt_next = user_deadtime;
            state_next    = DEAD;
          end
        end
      end
      DEAD: begin
        dead_cnt_next = dead_cnt - DT_W'(1);
        if (dead_cnt == DT_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (in_live && (req != '0) && !accept && (veto_cnt_next != 32'hFFFF_FFFF))
      veto_cnt_next = veto_cnt_next + 32'd1;

    busy_next = (state_next == DEAD) | in_daq_busy;
  end

  // Register everything; reset drops straight back to IDLE with cleared scalers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      dead_cnt         <= '0;
      rr_ptr           <= 4'd0;
      pre_live         <= 1'b0;
      out_lv1b         <= 1'b0;
      out_trig_type    <= 4'd0;
      out_trig_pattern <= '0;
      out_busy         <= 1'b0;
      accept_cnt       <= 32'd0;
      veto_cnt         <= 32'd0;
    end else begin
      state            <= state_next;
      dead_cnt         <= dead_cnt_next;
      rr_ptr           <= rr_ptr_next;
      pre_live         <= in_live;
      out_lv1b         <= lv1b_next;
      out_trig_type    <= type_next;
      out_trig_pattern <= pattern_next;
      out_busy         <= busy_next;
      accept_cnt       <= accept_cnt_next;
      veto_cnt         <= veto_cnt_next;
    end
  end

endmodule

// File: tb/tb_lv1b_trig_arbiter.sv
// Self-checking bench for lv1b_trig_arbiter.
// Directed scenarios are followed by randomized traffic.
// A reference model pushes expectations into queues that an independent monitor drains.
module tb_lv1b_trig_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_live, in_ena, in_daq_busy;
  logic [7:0]  in_trig_scaled;
  logic [15:0] user_deadtime;
  logic [7:0]  user_type_mask;
  logic        out_lv1b;
  logic [3:0]  out_trig_type;
  logic [7:0]  out_trig_pattern;
  logic        out_busy;
  logic [31:0] accept_cnt;
  logic [31:0] veto_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          lv1b;
    bit          busy;
    int unsigned acc;
    int unsigned veto;
    bit [3:0]    ttype;
    bit [7:0]    pat;
  } status_t;

  typedef struct {
    bit [3:0] ttype;
    bit [7:0] pat;
  } accept_t;

  status_t status_q[$];
  accept_t accept_q[$];

  // Reference model state: remaining dead cycles, fairness start, scalers, last grant
  int          m_dead;
  int          m_rr;
  int unsigned m_acc, m_veto;
  bit          m_prev_live;
  bit [3:0]    m_type;
  bit [7:0]    m_pat;

  lv1b_trig_arbiter #(.N_TYPE(8), .DT_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_live          (in_live),
    .in_ena           (in_ena),
    .in_daq_busy      (in_daq_busy),
    .in_trig_scaled   (in_trig_scaled),
    .user_deadtime    (user_deadtime),
    .user_type_mask   (user_type_mask),
    .out_lv1b         (out_lv1b),
    .out_trig_type    (out_trig_type),
    .out_trig_pattern (out_trig_pattern),
    .out_busy         (out_busy),
    .accept_cnt       (accept_cnt),
    .veto_cnt         (veto_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    m_dead      = 0;
    m_rr        = 0;
    m_acc       = 0;
    m_veto      = 0;
    m_prev_live = 1'b0;
    m_type      = '0;
    m_pat       = '0;
  endfunction

  function automatic int unsigned satInc(input int unsigned v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // Drive one cycle of inputs, predict what the next edge should produce, and queue it.
  task automatic applyStimulus(input bit live, input bit ena, input bit busy,
                               input bit [7:0] trig, input bit [15:0] dt, input bit [7:0] mask);
    bit [7:0] req;
    bit       acc_now;
    int       g;
    status_t  st;
    accept_t  ac;
    @(negedge clk);
    in_live        = live;
    in_ena         = ena;
    in_daq_busy    = busy;
    in_trig_scaled = trig;
    user_deadtime  = dt;
    user_type_mask = mask;

    if (live && !m_prev_live) begin
      m_acc  = 0;
      m_veto = 0;
      m_rr   = 0;
    end
    req     = trig & mask;
    acc_now = (m_dead == 0) && live && ena && !busy && (req != 0);
    if (acc_now) begin
      g = -1;
      for (int k = 0; k < 8; k++)
        if (g < 0 && req[(m_rr + k) % 8]) g = (m_rr + k) % 8;
      m_rr     = (g + 1) % 8;
      m_acc    = satInc(m_acc);
      m_type   = 4'(g);
      m_pat    = req;
      ac.ttype = m_type;
      ac.pat   = m_pat;
      accept_q.push_back(ac);
      m_dead   = int'(dt);
    end else if (m_dead > 0) begin
      m_dead--;
    end
    if (live && (req != 0) && !acc_now) m_veto = satInc(m_veto);
    m_prev_live = live;

    st.lv1b  = acc_now;
    st.busy  = (m_dead > 0) || busy;
    st.acc   = m_acc;
    st.veto  = m_veto;
    st.ttype = m_type;
    st.pat   = m_pat;
    status_q.push_back(st);
  endtask

  task automatic idleCycles(input int n, input bit live);
    for (int i = 0; i < n; i++) applyStimulus(live, 1'b1, 1'b0, 8'h00, 16'd0, 8'hFF);
  endtask

  // One live-low gap long enough to clear any pending deadtime, then the rising edge with no request
  task automatic restartRun();
    idleCycles(12, 1'b0);
    idleCycles(1, 1'b1);
  endtask

  task automatic waitSettle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every clocked cycle compares the DUT against the oldest queued expectation
  always @(posedge clk) begin
    status_t st;
    accept_t ac;
    #1;
    if (status_q.size() > 0) begin
      st = status_q.pop_front();
      checkOutput("lv1b", out_lv1b, st.lv1b);
      checkOutput("busy", out_busy, st.busy);
      checkOutput("accept_cnt", accept_cnt, st.acc);
      checkOutput("veto_cnt", veto_cnt, st.veto);
      checkOutput("held_type", out_trig_type, st.ttype);
      checkOutput("held_pattern", out_trig_pattern, st.pat);
      if (out_lv1b) begin
        if (accept_q.size() == 0) begin
          checkOutput("unexpected_accept", 1, 0);
        end else begin
          ac = accept_q.pop_front();
          checkOutput("grant_type", out_trig_type, ac.ttype);
          checkOutput("grant_pattern", out_trig_pattern, ac.pat);
        end
      end
    end
  end

  initial begin
    bit       live_r;
    bit [15:0] dt_r;
    bit [7:0]  mask_r;

    rst            = 1'b1;
    in_live        = 1'b0;
    in_ena         = 1'b0;
    in_daq_busy    = 1'b0;
    in_trig_scaled = '0;
    user_deadtime  = '0;
    user_type_mask = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_lv1b", out_lv1b, 0);
    checkOutput("reset_busy", out_busy, 0);
    checkOutput("reset_acc", accept_cnt, 0);
    rst = 1'b0;

    $display("[TB] idle after reset");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 8'h00);

    $display("[TB] single accept, no deadtime");
    restartRun();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h01, 16'd0, 8'hFF);
    waitSettle();
    checkOutput("t2_lv1b", out_lv1b, 1);
    checkOutput("t2_type", out_trig_type, 0);
    checkOutput("t2_acc", accept_cnt, 1);

    $display("[TB] deadtime of 5");
    restartRun();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h04, 16'd5, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 16'd5, 8'hFF);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h04, 16'd5, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h04, 16'd5, 8'hFF);
    waitSettle();
    checkOutput("t3_lv1b", out_lv1b, 1);
    checkOutput("t3_veto", veto_cnt, 4);
    checkOutput("t3_acc", accept_cnt, 2);

    $display("[TB] round robin between types 0 and 7");
    restartRun();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h81, 16'd0, 8'hFF);
      waitSettle();
      checkOutput("t4_rr_type", out_trig_type, (i % 2 == 0) ? 0 : 7);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h81, 16'd0, 8'h80);
      waitSettle();
      checkOutput("t4_mask_type", out_trig_type, 7);
    end
    checkOutput("t4_veto", veto_cnt, 0);
    checkOutput("t4_acc", accept_cnt, 6);

    $display("[TB] daq busy hold-off");
    restartRun();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 8'h02, 16'd0, 8'hFF);
    waitSettle();
    checkOutput("t5_veto", veto_cnt, 3);
    checkOutput("t5_busy", out_busy, 1);
    checkOutput("t5_acc", accept_cnt, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h02, 16'd0, 8'hFF);
    waitSettle();
    checkOutput("t5_after_busy", accept_cnt, 1);

    $display("[TB] live edge clears scalers, reset mid deadtime");
    restartRun();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h01, 16'd0, 8'hFF);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h01, 16'd0, 8'hFF);
    waitSettle();
    checkOutput("t6_acc_pre", accept_cnt, 3);
    checkOutput("t6_veto_pre", veto_cnt, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 16'd0, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h01, 16'd0, 8'hFF);
    waitSettle();
    checkOutput("t6_acc_edge", accept_cnt, 1);
    checkOutput("t6_veto_edge", veto_cnt, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h08, 16'd10, 8'hFF);
    idleCycles(3, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("t6_rst_busy", out_busy, 0);
    checkOutput("t6_rst_acc", accept_cnt, 0);
    checkOutput("t6_rst_veto", veto_cnt, 0);
    checkOutput("t6_rst_type", out_trig_type, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 16'd0, 8'hFF);
    waitSettle();
    checkOutput("t6_post_rst_lv1b", out_lv1b, 1);
    checkOutput("t6_post_rst_type", out_trig_type, 4);

    $display("[TB] randomized traffic");
    live_r = 1'b1;
    dt_r   = 16'd2;
    mask_r = 8'hFF;
    for (int i = 0; i < 3000; i++) begin
      bit [7:0] trig;
      if (live_r && $urandom_range(0, 99) == 0) live_r = 1'b0;
      else if (!live_r && $urandom_range(0, 3) == 0) live_r = 1'b1;
      if ($urandom_range(0, 49) == 0) dt_r = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) mask_r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      trig = '0;
      for (int b = 0; b < 8; b++) trig[b] = ($urandom_range(0, 9) < 2);
      applyStimulus(live_r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
                    trig, dt_r, mask_r);
    end

    idleCycles(3, 1'b0);
    waitSettle();
    waitSettle();
    checkOutput("status_queue_drained", status_q.size(), 0);
    checkOutput("accept_queue_drained", accept_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
